dut_pipeline: RTL and testbench
===============================

# dut_pipeline

Parametrised elastic pipeline that generalises the single-bit valid-gated test register into a WIDTH-bit, STAGES-deep datapath with a full valid/ready handshake, downstream backpressure, a synchronous flush and an occupancy counter. It is the standard DUT for the Tcl-driven simulation flow tests. Each stage is a two-entry skid buffer, so every handshake signal is registered and throughput is one word per cycle.

## Interface

Parameters:
- WIDTH, default 8: data width in bits; must be at least 1.
- STAGES, default 2: number of skid stages; must be at least 1. Any other value is an elaboration error.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst  in  1  reset; synchronous, active-high.
- i_flush  in  1  synchronous discard of all held words.
- i_valid  in  1  upstream word valid.
- i_data  in  WIDTH  upstream word.
- o_ready  out  1  pipeline can accept; registered.
- o_valid  out  1  downstream word valid; registered.
- o_data  out  WIDTH  downstream word; registered.
- i_ready  in  1  downstream accepts.
- o_level  out  $clog2(2*STAGES+1)  words currently held, 0 to 2*STAGES.

## Operation

- Transfers:
  - An input transfer occurs on an edge where i_valid and o_ready are both high.
  - An output transfer occurs on an edge where o_valid and i_ready are both high.
- Words leave the pipeline in exactly the order they entered. No word is lost, duplicated or reordered except by a flush.
- Stage state machine, per stage:
  - EMPTY: nothing held.
  - BUSY: main register holds one word.
  - FULL: main and skid registers both hold a word.
- Stage transitions:
  - EMPTY to BUSY on an input.
  - BUSY to EMPTY on an output with no input.
  - BUSY to FULL on an input with no output.
  - FULL to BUSY on an output; the skid word moves to the main register.
  - BUSY stays BUSY on a simultaneous input and output.
  - A stage has no other transitions.
- Stage handshake:
  - A stage's upstream ready is registered and equals "state is not FULL".
  - A stage's downstream valid equals "state is not EMPTY".
  - Each stage's output feeds the next stage's input. o_ready is stage 1's ready; o_valid and o_data come from the last stage.
- Occupancy (o_level):
  - +1 on an input transfer.
  - −1 on an output transfer.
  - Unchanged when both occur on the same edge.
  - It never exceeds 2*STAGES and never underflows.
- Flush:
  - At the next edge, every stage goes to EMPTY and o_level goes to 0.
  - An input presented on the same edge is dropped.
  - An output transfer on the same edge still counts as delivered.
  - Data registers are not cleared.
- Reset:
  - Has priority over flush.
  - Forces every stage to EMPTY and clears all data registers to '0.
  - Reset values: o_valid=0, o_data='0, o_ready=1, o_level=0. o_ready is 1 in the first cycle after reset.
  - Reset asserted mid-stream discards all held words; nothing is delivered afterwards.
- o_data is stable while o_valid=1 and i_ready=0.

## Timing

- Latency:
  - A word presented and accepted in cycle c appears on o_data with o_valid=1 in cycle c+STAGES.
  - This assumes every stage is unstalled.
  - STAGES=1 matches the original one-cycle register.
- Throughput: one word per cycle sustained while i_ready=1.
- Backpressure:
  - With i_ready held low, a stalled pipeline absorbs exactly 2*STAGES words.
  - o_ready falls in the cycle after the edge that fills stage 1.
  - That edge must not accept a word beyond capacity, because each skid register covers the one-cycle ready delay.
- Recovery: after i_ready rises, o_ready returns high no later than STAGES cycles later.
- No combinational path from any input to any output.

## Structure

- Package dut_pkg holds:
  - The stage state enum: EMPTY, BUSY, FULL.
  - A function returning the level width for a given STAGES.
- Sub-module dut_skid_stage (parameter WIDTH):
  - One two-entry skid buffer with the i_clk, i_rst and i_flush ports plus valid/ready/data on each side.
  - dut_pipeline instantiates it STAGES times in a generate loop and owns the o_level counter.

## Test plan

- Reset: hold i_rst 2 cycles with random inputs → o_valid=0, o_data=0, o_level=0, o_ready=1 in the first post-reset cycle.
- Latency: WIDTH=8, STAGES=3, i_ready=1; present 0xA5 for one cycle in cycle 10 → o_valid=1, o_data=0xA5 in cycle 13 only; o_level is 1 throughout.
- Throughput: stream 0x00..0xFF back-to-back with i_ready=1 → 256 consecutive output words in order, no bubbles, o_level constant at STAGES.
- Backpressure:
  - Hold i_ready=0 and offer words every cycle → exactly 2*STAGES accepted; o_ready=0; o_level=2*STAGES; o_data stable.
  - Then release i_ready → all words drained in order and o_level returns to 0.
- Flush:
  - Fill 3 words, then assert i_flush with i_valid=1 → o_level=0 and o_valid=0 next cycle; the flushed and simultaneous words never appear.
  - Then send 0x3C → 0x3C is the next output.
- Reset mid-stream: assert i_rst while o_level=4 and i_ready=0 → held words never emerge; reset values are restored; a following transfer behaves as in the Latency scenario.

Source files
------------

// File: rtl/dut_pkg.sv
// Shared types and helpers for the elastic pipeline.
// Stage state encoding and level-counter sizing.
package dut_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } stage_state_e;

  function automatic int level_w(input int stages);
    return $clog2(2 * stages + 1);
  endfunction

endpackage

// File: rtl/dut_skid_stage.sv
// One two-entry skid buffer with registered handshakes.
// The skid register absorbs the word in flight while ready drops.
module dut_skid_stage
  import dut_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  input  logic             i_ready
);

  stage_state_e     state;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             ready_q;
  logic             valid_q;
  logic             in_xfer;
  logic             out_xfer;

  assign in_xfer  = i_valid & ready_q;
  assign out_xfer = valid_q & i_ready;

  assign o_ready = ready_q;
  assign o_valid = valid_q;
  assign o_data  = main_q;

  // Stage FSM; ready/valid are registered alongside the state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else if (i_flush) begin
      state   <= EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_xfer) begin
            main_q  <= i_data;
            state   <= BUSY;
            valid_q <= 1'b1;
          end
        end
        BUSY: begin
          if (in_xfer && !out_xfer) begin
            skid_q  <= i_data;
            state   <= FULL;
            ready_q <= 1'b0;
          end else if (!in_xfer && out_xfer) begin
            state   <= EMPTY;
            valid_q <= 1'b0;
          end else if (in_xfer && out_xfer) begin
            main_q <= i_data;
          end
        end
        FULL: begin
          if (out_xfer) begin
            main_q  <= skid_q;
            state   <= BUSY;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state   <= EMPTY;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/dut_pipeline.sv
// Elastic WIDTH x STAGES pipeline of skid stages.
// Owns the occupancy counter; stages carry the data.
module dut_pipeline
  import dut_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_flush,
  input  logic                         i_valid,
  input  logic [WIDTH-1:0]             i_data,
  output logic                         o_ready,
  output logic                         o_valid,
  output logic [WIDTH-1:0]             o_data,
  input  logic                         i_ready,
  output logic [level_w(STAGES)-1:0]   o_level
);

  localparam int LW = level_w(STAGES);

  if (WIDTH < 1 || STAGES < 1) begin : g_bad_param
    $error("dut_pipeline: WIDTH and STAGES must be >= 1");
  end

  logic [STAGES:0]  vld;
  logic [STAGES:0]  rdy;
  logic [WIDTH-1:0] dat [STAGES+1];
  logic [LW-1:0]    level_q;
  logic             in_xfer;
  logic             out_xfer;

  assign vld[0]      = i_valid;
  assign dat[0]      = i_data;
  assign rdy[STAGES] = i_ready;
  assign o_ready     = rdy[0];
  assign o_valid     = vld[STAGES];
  assign o_data      = dat[STAGES];

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    dut_skid_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_flush(i_flush),
      .i_valid(vld[g]),
      .i_data (dat[g]),
      .o_ready(rdy[g]),
      .o_valid(vld[g+1]),
      .o_data (dat[g+1]),
      .i_ready(rdy[g+1])
    );
  end

  assign in_xfer  = i_valid & rdy[0];
  assign out_xfer = vld[STAGES] & i_ready;
  assign o_level  = level_q;

  // Occupancy: +1 per input, -1 per output, cleared by flush.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      level_q <= '0;
    end else if (i_flush) begin
      level_q <= '0;
    end else if (in_xfer && !out_xfer) begin
      level_q <= level_q + 1'b1;
    end else if (!in_xfer && out_xfer) begin
      level_q <= level_q - 1'b1;
    end
  end

endmodule

// File: tb/tb_dut_pipeline.sv
// Self-checking bench for dut_pipeline (WIDTH=8, STAGES=3).
// Scoreboard queue plus a vector table and directed sequences.
module tb_dut_pipeline;
  import dut_pkg::*;

  localparam int WIDTH  = 8;
  localparam int STAGES = 3;
  localparam int LW     = level_w(STAGES);

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic             i_flush;
  logic             i_valid;
  logic [WIDTH-1:0] i_data;
  logic             o_ready;
  logic             o_valid;
  logic [WIDTH-1:0] o_data;
  logic             i_ready;
  logic [LW-1:0]    o_level;

  dut_pipeline #(
    .WIDTH (WIDTH),
    .STAGES(STAGES)
  ) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_flush(i_flush),
    .i_valid(i_valid),
    .i_data (i_data),
    .o_ready(o_ready),
    .o_valid(o_valid),
    .o_data (o_data),
    .i_ready(i_ready),
    .o_level(o_level)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic             rst;
    logic             flush;
    logic             valid;
    logic [WIDTH-1:0] data;
    logic             ready;
    bit               chk;
    bit               dchk;
    logic             e_valid;
    logic [WIDTH-1:0] e_data;
    logic             e_ready;
    int               e_level;
  } vec_t;

  vec_t             tbl [15];
  logic [WIDTH-1:0] sb_q [$];
  int               n_cmp = 0;
  int               n_err = 0;
  int               n_in  = 0;
  int               n_out = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: runs once per cycle at the falling edge.
  task automatic sample();
    @(negedge i_clk);
    if (i_rst) begin
      sb_q.delete();
    end else begin
      chk("level_vs_model", 32'(o_level), 32'(sb_q.size()));
      if (o_valid && i_ready) begin
        n_out++;
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL out_unexpected: got %0h expected no word", o_data);
        end else begin
          chk("out_order", 32'(o_data), 32'(sb_q.pop_front()));
        end
      end
      if (i_flush) begin
        sb_q.delete();
      end else if (i_valid && o_ready) begin
        sb_q.push_back(i_data);
        n_in++;
      end
    end
  endtask

  task automatic next_edge();
    @(posedge i_clk);
    #1;
  endtask

  function automatic vec_t mk(input logic rst, input logic valid,
                              input logic [WIDTH-1:0] data,
                              input logic ready, input bit c,
                              input bit dc, input logic ev,
                              input logic [WIDTH-1:0] ed,
                              input logic er, input int el);
    vec_t v;
    v.rst = rst; v.flush = 1'b0; v.valid = valid; v.data = data;
    v.ready = ready; v.chk = c; v.dchk = dc; v.e_valid = ev;
    v.e_data = ed; v.e_ready = er; v.e_level = el;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int  o0;
    int  i0;
    int  t_rec;
    bit  seen;
    bit  got;

    i_rst = 1'b1; i_flush = 1'b0; i_valid = 1'b0;
    i_data = '0; i_ready = 1'b0;

    // Reset with random inputs, then latency of one word in cycle 10.
    for (int i = 0; i < 2; i++)
      tbl[i] = mk(1'b1, 1'($urandom), 8'($urandom), 1'($urandom),
                  0, 0, 0, 0, 0, 0);
    tbl[2] = mk(0, 0, 0, 1, 1, 1, 0, 8'h00, 1, 0);
    for (int i = 3; i < 10; i++)
      tbl[i] = mk(0, 0, 0, 1, 1, 0, 0, 0, 1, 0);
    tbl[10] = mk(0, 1, 8'hA5, 1, 1, 0, 0, 0, 1, 0);
    tbl[11] = mk(0, 0, 0, 1, 1, 0, 0, 0, 1, 1);
    tbl[12] = mk(0, 0, 0, 1, 1, 0, 0, 0, 1, 1);
    tbl[13] = mk(0, 0, 0, 1, 1, 1, 1, 8'hA5, 1, 1);
    tbl[14] = mk(0, 0, 0, 1, 1, 0, 0, 0, 1, 0);

    next_edge();
    for (int i = 0; i < 15; i++) begin
      i_rst = tbl[i].rst; i_flush = tbl[i].flush;
      i_valid = tbl[i].valid; i_data = tbl[i].data;
      i_ready = tbl[i].ready;
      sample();
      if (tbl[i].chk) begin
        chk($sformatf("tbl%0d_valid", i), 32'(o_valid),
            32'(tbl[i].e_valid));
        chk($sformatf("tbl%0d_ready", i), 32'(o_ready),
            32'(tbl[i].e_ready));
        chk($sformatf("tbl%0d_level", i), 32'(o_level),
            32'(tbl[i].e_level));
        if (tbl[i].dchk)
          chk($sformatf("tbl%0d_data", i), 32'(o_data),
              32'(tbl[i].e_data));
      end
      next_edge();
    end

    // Throughput: 256 back-to-back words, no bubbles.
    o0 = n_out;
    for (int k = 0; k < 256 + STAGES; k++) begin
      i_valid = (k < 256); i_data = 8'(k); i_ready = 1'b1;
      sample();
      if (k >= STAGES) chk("tput_valid", 32'(o_valid), 1);
      if (k < 256) chk("tput_ready", 32'(o_ready), 1);
      if (k >= STAGES && k <= 256)
        chk("tput_level", 32'(o_level), STAGES);
      next_edge();
    end
    chk("tput_count", 32'(n_out - o0), 256);
    i_valid = 1'b0;
    sample();
    next_edge();

    // Backpressure: exactly 2*STAGES absorbed, head word held.
    i0 = n_in; o0 = n_out;
    i_ready = 1'b0; i_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      i_data = 8'(8'h10 + k);
      sample();
      if (o_valid) chk("bp_hold", 32'(o_data), 32'h10);
      next_edge();
    end
    i_valid = 1'b0;
    sample();
    chk("bp_accepted", 32'(n_in - i0), 2 * STAGES);
    chk("bp_ready", 32'(o_ready), 0);
    chk("bp_level", 32'(o_level), 2 * STAGES);
    chk("bp_data", 32'(o_data), 32'h10);
    next_edge();
    i_ready = 1'b1;
    seen = 0; t_rec = 99;
    for (int t = 0; t < 20; t++) begin
      sample();
      if (o_ready && !seen) begin
        seen = 1; t_rec = t;
      end
      next_edge();
    end
    chk("bp_recover", 32'(seen && t_rec <= STAGES), 1);
    sample();
    chk("bp_drain_level", 32'(o_level), 0);
    chk("bp_drain_count", 32'(n_out - o0), 2 * STAGES);
    next_edge();

    // Flush: three held words plus a same-edge word are discarded.
    i_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      i_valid = 1'b1; i_data = 8'(8'h51 + k);
      sample();
      next_edge();
    end
    i_flush = 1'b1; i_data = 8'h54;
    sample();
    next_edge();
    i_flush = 1'b0; i_valid = 1'b0;
    sample();
    chk("flush_level", 32'(o_level), 0);
    chk("flush_valid", 32'(o_valid), 0);
    next_edge();
    i_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      sample();
      next_edge();
    end
    i_valid = 1'b1; i_data = 8'h3C;
    sample();
    next_edge();
    i_valid = 1'b0;
    got = 0;
    for (int k = 0; k < 10; k++) begin
      sample();
      if (o_valid && !got) begin
        got = 1;
        chk("flush_next_word", 32'(o_data), 32'h3C);
      end
      next_edge();
    end
    chk("flush_next_seen", 32'(got), 1);

    // Reset mid-stream with four words held under backpressure.
    i_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      i_valid = 1'b1; i_data = 8'(8'h61 + k);
      sample();
      next_edge();
    end
    i_valid = 1'b0;
    sample();
    chk("mrst_level_before", 32'(o_level), 4);
    next_edge();
    i_rst = 1'b1;
    sample();
    next_edge();
    i_rst = 1'b0; i_ready = 1'b1;
    sample();
    chk("mrst_valid", 32'(o_valid), 0);
    chk("mrst_data", 32'(o_data), 0);
    chk("mrst_ready", 32'(o_ready), 1);
    chk("mrst_level", 32'(o_level), 0);
    next_edge();
    for (int k = 0; k < 3; k++) begin
      sample();
      next_edge();
    end
    i_valid = 1'b1; i_data = 8'hC3;
    sample();
    next_edge();
    i_valid = 1'b0;
    for (int d = 1; d <= 5; d++) begin
      sample();
      chk($sformatf("mrst_lat_valid_c%0d", d), 32'(o_valid),
          32'(d == STAGES));
      if (d == STAGES) chk("mrst_lat_data", 32'(o_data), 32'hC3);
      next_edge();
    end
    sample();
    chk("final_level", 32'(o_level), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
